adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pkg.sv | 14 +
 rtl/adder_slice.sv | 22 ++
 rtl/adder_pipe.sv | 146 ++++++++++++++
 tb/tb_adder_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunked pipelined adder.
package adder_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_CHUNK = 4;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      ADC = 2'd2,
      SBB = 2'd3
   } op_t;

endpackage

// File: rtl/adder_slice.sv
// One CHUNK-bit ripple slice: sum, carry out, and the carry into its MSB
// (the latter feeds signed-overflow detection in the top slice).
module adder_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] full;

   assign full  = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
   assign sum   = full[CHUNK-1:0];
   assign cout  = full[CHUNK];
   // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
   assign c_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/adder_pipe.sv
// Carry-pipelined adder/subtractor: chunk k resolves in stage k, upper operand
// chunks ride along behind it. Define ADDER_PIPE_SAT_EN for signed saturation.
module adder_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CHUNK = DEFAULT_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             cout,
   output logic             oflow,
   output logic             zero
);

   localparam int STAGES = WIDTH / CHUNK;

   if (WIDTH % CHUNK != 0) begin : g_size_check
      $error("adder_pipe: WIDTH must be a multiple of CHUNK");
   end

   logic             advance;
   logic [WIDTH-1:0] b_op;
   logic             c_first;

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_cur;
   logic [STAGES-1:0] c_cur;
   logic [STAGES-1:0] sl_co;
   logic              c_q    [STAGES];
   logic              sl_cm  [STAGES];
   logic [CHUNK-1:0]  sl_sum [STAGES];
   logic [WIDTH-1:0]  a_cur  [STAGES];
   logic [WIDTH-1:0]  b_cur  [STAGES];
   logic [WIDTH-1:0]  s_cur  [STAGES];
   logic [WIDTH-1:0]  s_nx   [STAGES];
   logic [WIDTH-1:0]  a_q    [STAGES];
   logic [WIDTH-1:0]  b_q    [STAGES];
   logic [WIDTH-1:0]  s_q    [STAGES];

   logic [WIDTH-1:0] z_raw;
   logic [WIDTH-1:0] z_fin;
   logic             ovf_raw;

   assign advance   = !v_q[STAGES-1] || out_ready;
   assign in_ready  = advance;
   assign out_valid = v_q[STAGES-1];

   // subtraction is a + ~b + carry-in; cin only matters for ADC/SBB
   always_comb begin
      b_op    = b;
      c_first = 1'b0;
      case (op)
         ADD:     begin b_op = b;  c_first = 1'b0; end
         SUB:     begin b_op = ~b; c_first = 1'b1; end
         ADC:     begin b_op = b;  c_first = cin;  end
         SBB:     begin b_op = ~b; c_first = !cin; end
         default: begin b_op = b;  c_first = 1'b0; end
      endcase
   end

   always_comb begin
      v_cur    = '0;
      c_cur    = '0;
      a_cur[0] = a;
      b_cur[0] = b_op;
      s_cur[0] = '0;
      c_cur[0] = c_first;
      v_cur[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_cur[k] = a_q[k-1];
         b_cur[k] = b_q[k-1];
         s_cur[k] = s_q[k-1];
         c_cur[k] = c_q[k-1];
         v_cur[k] = v_q[k-1];
      end
   end

   // operands shift right one chunk per stage; finished chunks shift in from the top
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_slice #(.CHUNK(CHUNK)) u_slice (
         .a     (a_cur[k][CHUNK-1:0]),
         .b     (b_cur[k][CHUNK-1:0]),
         .cin   (c_cur[k]),
         .sum   (sl_sum[k]),
         .cout  (sl_co[k]),
         .c_msb (sl_cm[k])
      );
      assign s_nx[k] = (s_cur[k] >> CHUNK) | (WIDTH'(sl_sum[k]) << (WIDTH - CHUNK));
   end

   assign z_raw   = s_nx[STAGES-1];
   assign ovf_raw = sl_cm[STAGES-1] ^ sl_co[STAGES-1];

`ifdef ADDER_PIPE_SAT_EN
   // a's MSB is the low chunk's top bit by the time it reaches the last stage
   always_comb begin
      z_fin = z_raw;
      if (ovf_raw) begin
         z_fin = a_cur[STAGES-1][CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign z_fin = z_raw;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         z     <= '0;
         cout  <= 1'b0;
         oflow <= 1'b0;
         zero  <= 1'b0;
      end else if (advance) begin
         v_q <= v_cur;
         if (v_cur[STAGES-1]) begin
            z     <= z_fin;
            cout  <= sl_co[STAGES-1];
            oflow <= ovf_raw;
            zero  <= (z_fin == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_cur[k] >> CHUNK;
            b_q[k] <= b_cur[k] >> CHUNK;
            s_q[k] <= s_nx[k];
            c_q[k] <= sl_co[k];
         end
      end
   end

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (WIDTH=16, CHUNK=4); honours ADDER_PIPE_SAT_EN.
module tb_adder_pipe;
   import adder_pkg::*;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;

`ifdef ADDER_PIPE_SAT_EN
   localparam logic [15:0] Z_SUBOV = 16'h8000;
   localparam logic [15:0] Z_ADDOV = 16'h7FFF;
   localparam logic [15:0] Z_ADCOV = 16'h8000;
   localparam logic        ZR_ADCOV = 1'b0;
`else
   localparam logic [15:0] Z_SUBOV = 16'h7FFF;
   localparam logic [15:0] Z_ADDOV = 16'h8000;
   localparam logic [15:0] Z_ADCOV = 16'h0000;
   localparam logic        ZR_ADCOV = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   op_t         op = ADD;
   logic        cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] z;
   logic        cout;
   logic        oflow;
   logic        zero;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   adder_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .cout      (cout),
      .oflow     (oflow),
      .zero      (zero)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      op_t         op;
      logic        cin;
      logic [15:0] z;
      logic        cout;
      logic        oflow;
      logic        zero;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // whole-width reference: {z, cout, oflow, zero}
   function automatic logic [18:0] model(input logic [15:0] fa, input logic [15:0] fb,
                                         input op_t fop, input logic fcin);
      logic [15:0] bb;
      logic        c0;
      logic [16:0] full;
      logic        cm;
      logic        ov;
      logic [15:0] zz;
      bb   = (fop == SUB || fop == SBB) ? ~fb : fb;
      c0   = (fop == SUB) ? 1'b1 : (fop == ADC) ? fcin : (fop == SBB) ? !fcin : 1'b0;
      full = {1'b0, fa} + {1'b0, bb} + 17'(c0);
      cm   = full[15] ^ fa[15] ^ bb[15];
      ov   = cm ^ full[16];
      zz   = full[15:0];
`ifdef ADDER_PIPE_SAT_EN
      if (ov) zz = fa[15] ? 16'h8000 : 16'h7FFF;
`endif
      return {zz, full[16], ov, (zz == 16'h0000)};
   endfunction

   logic [18:0] sexp [8];
   logic [18:0] q [$];
   logic [15:0] held;
   logic [19:0] last;
   logic        hold_pend;
   int          si, ri, acc, got, cyc, lat;

   initial begin
      vecs[0] = '{16'h00FF, 16'h0001, ADD, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h8000, 16'h0001, SUB, 1'b0, Z_SUBOV,  1'b1, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0000, ADC, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{16'h0005, 16'h0005, SBB, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{16'h7FFF, 16'h0001, ADD, 1'b0, Z_ADDOV,  1'b0, 1'b1, 1'b0};
      vecs[5] = '{16'h1234, 16'h1234, SUB, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{16'h0001, 16'h0001, ADD, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{16'h0000, 16'h0001, SUB, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{16'h8000, 16'h8000, ADC, 1'b0, Z_ADCOV,  1'b1, 1'b1, ZR_ADCOV};
      vecs[9] = '{16'h0010, 16'h0001, SBB, 1'b0, 16'h000F, 1'b1, 1'b0, 1'b0};

      // reset values
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_z", z, 0);
      check("rst_cout", cout, 0);
      check("rst_oflow", oflow, 0);
      check("rst_zero", zero, 0);

      // directed table, one op at a time
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; cin = vecs[i].cin;
         in_valid = 1'b1;
         @(negedge clk);
         check("tbl_in_ready", in_ready, 1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check($sformatf("tbl%0d_latency", i), lat, 4);
         check($sformatf("tbl%0d_z", i), z, vecs[i].z);
         check($sformatf("tbl%0d_cout", i), cout, vecs[i].cout);
         check($sformatf("tbl%0d_oflow", i), oflow, vecs[i].oflow);
         check($sformatf("tbl%0d_zero", i), zero, vecs[i].zero);
      end

      // 8 back-to-back ops with out_ready low in cycles 5..7
      for (int i = 0; i < 8; i++)
         sexp[i] = model(16'(i * 16'h1111), 16'h0F0F ^ 16'(i), op_t'(i % 4), 1'(i));
      si = 0;
      ri = 0;
      held = '0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         in_valid  = (si < 8);
         a         = 16'(si * 16'h1111);
         b         = 16'h0F0F ^ 16'(si);
         op        = op_t'(si % 4);
         cin       = 1'(si);
         out_ready = !(c >= 5 && c <= 7);
         @(negedge clk);
         check("stall_in_ready", in_ready, !(c >= 5 && c <= 7));
         if (c == 5) held = z;
         if (c == 6 || c == 7) begin
            check("stall_hold_z", z, held);
            check("stall_hold_valid", out_valid, 1);
         end
         if (in_valid && in_ready) si++;
         if (out_valid && out_ready) begin
            if (ri < 8) check($sformatf("stall_res%0d", ri), {z, cout, oflow, zero}, sexp[ri]);
            ri++;
         end
      end
      check("stall_sent", si, 8);
      check("stall_recv", ri, 8);
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // reset with 3 ops in flight
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         a = 16'(c + 1); b = 16'h0001; op = ADD; cin = 1'b0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_z", z, 0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("midrst_no_stale", out_valid, 0);
      end

      // random traffic against the reference model
      acc = 0;
      got = 0;
      cyc = 0;
      hold_pend = 1'b0;
      last = '0;
      while (got < 10000 && cyc < 60000) begin
         @(posedge clk);
         #1;
         in_valid  = ($urandom_range(0, 9) < 7) && (acc < 10000);
         a         = 16'($urandom);
         b         = 16'($urandom);
         op        = op_t'($urandom_range(0, 3));
         cin       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (hold_pend) check("rnd_hold", {out_valid, z, cout, oflow, zero}, last);
         hold_pend = out_valid && !out_ready;
         last = {out_valid, z, cout, oflow, zero};
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, op, cin));
            acc++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rnd_spurious: got result 0x%0h with no op outstanding", z);
            end else begin
               check("rnd_result", {z, cout, oflow, zero}, q.pop_front());
            end
            got++;
         end
         cyc++;
      end
      check("rnd_count", got, 10000);
      check("rnd_queue_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
